// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with clock enable, runtime seed load,
// all-zero lockup protection and on-line period measurement.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'h240,
  parameter logic [WIDTH-1:0] SEED  = 10'h26E
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q_out,
  output logic             max_tick,
  output logic [WIDTH-1:0] period_len,
  output logic             period_valid,
  output logic             lockup
);

  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] len_q, len_d;
  logic             tick_q, tick_d;
  logic             valid_q, valid_d;
  logic             lock_q, lock_d;
  logic             fb;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    fb  = ^(state_q & TAPS);
    nxt = {state_q[WIDTH-2:0], fb};
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    valid_d = valid_q;
    tick_d  = 1'b0;
    lock_d  = 1'b0;
    if (load) begin
      // A zero seed would freeze the register, so fall back to SEED and flag it.
      if (load_val != '0) begin
        state_d = load_val;
        ref_d   = load_val;
      end else begin
        state_d = SEED;
        ref_d   = SEED;
        lock_d  = 1'b1;
      end
      cnt_d = '0;
    end else if (en) begin
      state_d = nxt;
      if (nxt == ref_q) begin
        tick_d  = 1'b1;
        len_d   = cnt_q + WIDTH'(1);
        valid_d = 1'b1;
        cnt_d   = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
      ref_q   <= SEED;
      cnt_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      tick_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      tick_q  <= tick_d;
      lock_q  <= lock_d;
    end
  end

  assign q_out        = state_q;
  assign max_tick     = tick_q;
  assign period_len   = len_q;
  assign period_valid = valid_q;
  assign lockup       = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: polynomial-level reference model checked every cycle,
// plus directed sequences with hand-computed values.
module tb_lfsr_gen;
  localparam logic [9:0] TAPS = 10'h240;
  localparam logic [9:0] SEED = 10'h26E;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [9:0] load_val;
  logic [9:0] q, plen;
  logic       tick, pvalid, lock;
  logic [3:0] q4, plen4;
  logic       tick4, pvalid4, lock4;

  int total = 0;
  int bad   = 0;

  lfsr_gen dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .q_out(q), .max_tick(tick), .period_len(plen), .period_valid(pvalid), .lockup(lock)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut4 (
    .clk(clk), .rst(rst), .en(en), .load(1'b0), .load_val(4'h0),
    .q_out(q4), .max_tick(tick4), .period_len(plen4), .period_valid(pvalid4), .lockup(lock4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: polynomial recurrence over plain integers.
  int m_state, m_ref, m_cnt, m_len;
  bit m_valid, m_tick, m_lock, m_init = 0;

  function automatic int poly_next(input int s);
    int fbit;
    fbit = $countones(s & int'(TAPS)) % 2;
    return ((s * 2) % 1024) + fbit;
  endfunction

  always @(posedge clk) begin
    int nx;
    if (rst) begin
      m_state = SEED; m_ref = SEED; m_cnt = 0; m_len = 0;
      m_valid = 0; m_tick = 0; m_lock = 0; m_init = 1;
    end else if (load) begin
      m_tick = 0;
      m_cnt  = 0;
      if (load_val == 0) begin m_state = SEED; m_ref = SEED; m_lock = 1; end
      else begin m_state = load_val; m_ref = load_val; m_lock = 0; end
    end else if (en) begin
      m_lock = 0;
      nx = poly_next(m_state);
      m_state = nx;
      if (nx == m_ref) begin
        m_tick = 1; m_len = m_cnt + 1; m_valid = 1; m_cnt = 0;
      end else begin
        m_tick = 0;
        if (m_cnt < 1023) m_cnt++;
      end
    end else begin
      m_tick = 0; m_lock = 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("model_q", q, m_state);
      check("model_tick", tick, m_tick);
      check("model_len", plen, m_len);
      check("model_valid", pvalid, m_valid);
      check("model_lock", lock, m_lock);
      check("nonzero_q", (q != 0), 1);
    end
  end

  bit vis [0:1023];
  int distinct, ticks, steps, guard;
  bit seen;
  logic [9:0] held;

  initial begin
    rst = 1; en = 0; load = 0; load_val = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_q", q, 10'h26E);
    check("rst_tick", tick, 0);
    check("rst_len", plen, 0);
    check("rst_valid", pvalid, 0);
    check("rst_lock", lock, 0);
    check("rst_q4", q4, 4'h1);

    // First steps from SEED
    en = 1;
    @(negedge clk); check("step1", q, 10'h0DC);
    @(negedge clk); check("step2", q, 10'h1B9);
    check("step2_tick", tick, 0);
    check("step2_valid", pvalid, 0);

    // Full period: every non-zero state exactly once
    foreach (vis[i]) vis[i] = 0;
    vis[10'h0DC] = 1; vis[10'h1B9] = 1; distinct = 2; ticks = 0;
    repeat (1021) begin
      @(negedge clk);
      if (!vis[q]) begin vis[q] = 1; distinct++; end
      if (tick) ticks++;
    end
    check("full_distinct", distinct, 1023);
    check("full_ticks", ticks, 1);
    check("wrap_tick", tick, 1);
    check("wrap_q", q, 10'h26E);
    check("wrap_len", plen, 1023);
    check("wrap_valid", pvalid, 1);
    check("w4_len", plen4, 15);
    check("w4_valid", pvalid4, 1);

    // load and en together: load wins, no step
    load = 1; load_val = 10'h001; en = 1;
    @(negedge clk);
    load = 0;
    check("load_q", q, 10'h001);
    check("load_tick", tick, 0);
    check("load_len_hold", plen, 1023);
    @(negedge clk); check("load_step1", q, 10'h002);

    // Run to wrap, with en low for 5 cycles mid-run
    steps = 1; guard = 0; seen = 0;
    while (!seen && guard < 3000) begin
      if (steps == 300) begin
        en = 0; held = q;
        repeat (5) @(negedge clk);
        check("idle_hold", q, held);
        en = 1;
      end
      @(negedge clk);
      steps++; guard++;
      if (tick) seen = 1;
    end
    check("load_wrap_seen", seen, 1);
    check("load_wrap_steps", steps, 1023);
    check("load_wrap_q", q, 10'h001);
    check("load_wrap_len", plen, 1023);

    // Zero load rejected
    load = 1; load_val = 10'h000;
    @(negedge clk);
    load = 0;
    check("zload_q", q, 10'h26E);
    check("zload_lock", lock, 1);
    check("zload_tick", tick, 0);
    check("zload_len", plen, 1023);
    @(negedge clk);
    check("zload_step", q, 10'h0DC);
    check("zload_lock_clr", lock, 0);

    // Reset at step 500
    repeat (499) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("mrst_q", q, 10'h26E);
    check("mrst_len", plen, 0);
    check("mrst_valid", pvalid, 0);
    check("mrst_len4", plen4, 0);

    steps = 0; guard = 0; seen = 0;
    while (!seen && guard < 3000) begin
      @(negedge clk);
      steps++; guard++;
      if (tick) seen = 1;
    end
    check("seed_wrap_seen", seen, 1);
    check("seed_wrap_steps", steps, 1023);
    check("seed_wrap_len", plen, 1023);
    check("w4_len_again", plen4, 15);

    en = 0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR generator; successor to the fixed 10-bit LFSR.
- Adds generic width and tap mask, clock enable, and runtime seed load.
- Adds all-zero lockup protection and on-line period measurement with a wrap tick.
- Used as pseudo-random source and self-check for pattern/test logic on the Basys3 top level.

Parameters:
- WIDTH, 10, register width in bits (>= 3).
- TAPS, 10'h240, feedback mask [WIDTH-1:0]: bit i = 1 means state bit i is XORed into feedback (default gives s[9]^s[6], i.e. x^10+x^7+1).
- SEED, 10'h26E, reset/recovery state; must be non-zero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  advance one step this cycle.
- load  in  1  load load_val this cycle.
- load_val  in  WIDTH  new state and new reference.
- q_out  out  WIDTH  current state register.
- max_tick  out  1  one-cycle pulse: state has just returned to the reference.
- period_len  out  WIDTH  last measured cycle length, in steps.
- period_valid  out  1  period_len holds at least one measurement.
- lockup  out  1  one-cycle pulse: zero load rejected.

Behaviour:
- One clock; reset is synchronous and active-high. All actions occur on posedge clk. Priority is rst > load > en.
- Reset values:
  - state = SEED, ref = SEED, step_cnt = 0.
  - max_tick = 0, period_len = 0, period_valid = 0, lockup = 0.
- Feedback: fb = XOR over i of (state[i] & TAPS[i]). Next state nxt = {state[WIDTH-2:0], fb}.
- Step (en=1, load=0, rst=0):
  - state <= nxt.
  - If nxt == ref: max_tick <= 1, period_len <= step_cnt+1, period_valid <= 1, step_cnt <= 0.
  - Otherwise: max_tick <= 0, step_cnt <= step_cnt+1, saturating at all-ones (non-primitive TAPS may never return to ref).
- Idle (en=0, load=0): state, ref and counters hold; max_tick and lockup go to 0.
- Load (load=1, overrides en, no step taken):
  - load_val != 0: state <= load_val, ref <= load_val, step_cnt <= 0, lockup <= 0.
  - load_val == 0: state <= SEED, ref <= SEED, step_cnt <= 0, lockup <= 1.
  - In both cases max_tick <= 0; period_len and period_valid hold.
- Lockup protection: the state can never be all-zero.
- Timing:
  - max_tick is high in the same cycle q_out first equals ref after a wrap.
  - max_tick is never high after reset or after a load alone.
- period_len updates only on a wrap. It keeps its last value across loads; reset clears it.
- Latency: q_out is registered and reflects a step or load one cycle after the enabling edge. No combinational path exists from inputs to outputs.
- Reset mid-sequence discards the current measurement. The next wrap measures from SEED.

Test Plan:
- Reset with defaults, then en=1 for 2 cycles -> q_out sequence 0x26E, 0x0DC, 0x1B9; max_tick=0, period_valid=0.
- Defaults, en=1 continuously -> max_tick pulses exactly once per 1023 steps with q_out=0x26E; then period_len=1023, period_valid=1. Scoreboard confirms all 1023 non-zero states are visited once.
- load=1 with load_val=0x001, then en=1 -> q_out=0x001 next cycle, then 0x002; next max_tick occurs 1023 steps later with q_out=0x001.
- load=1 with load_val=0 -> q_out=0x26E, lockup=1 for exactly one cycle, max_tick=0; the following step gives 0x0DC.
- Assert load and en together, then en alone; also toggle en low for 5 cycles mid-run -> with load+en, load wins and no step is taken; during en=0, q_out and step_cnt hold, so the measured period is still 1023.
- Assert rst at step 500 mid-run -> next cycle q_out=0x26E and period_len=0; WIDTH=4, TAPS=4'hC, SEED=4'h1 run -> period_len=15.
